dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/rr_pick2.sv | 19 +
 rtl/dmem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // Arbiter ownership state: free, or locked to one port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int unsigned P_CPU         = 0;
  localparam int unsigned P_DMA         = 1;
  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned BCNT_W        = 4;
  localparam int unsigned GCNT_W        = 16;

endpackage : dmem_arb_pkg

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: one-hot grant, prio wins ties.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  // Single requester wins outright; on a tie the prio port wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule : rr_pick2

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory (port 0 = CPU,
// port 1 = DMA/debug). Round-robin with bounded burst lock; grant and
// memory mux are combinational, load data is registered per port.
// Optional grant statistics enabled by defining ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
`ifdef ARB_STATS_EN
  ,
  output logic [GCNT_W-1:0] gcnt0,
  output logic [GCNT_W-1:0] gcnt1,
  output logic              contention
`endif
);

  // A burst of one grant is no burst at all: lock never takes effect.
  localparam logic LOCK_OK = (MAX_BURST > 1);
  localparam logic [BCNT_W-1:0] BURST_LIM = BCNT_W'(MAX_BURST);

  arb_state_t        state_q, state_d;
  logic              prio_q, prio_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [1:0]        pick_gnt;
  logic [1:0]        gnt_c;
  logic              load0_c, load1_c;

  rr_pick2 u_pick (
    .req  ({req1, req0}),
    .prio (prio_q),
    .gnt  (pick_gnt)
  );

  // Grant decision and next ownership / priority / burst count.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    bcnt_d  = bcnt_q;
    gnt_c   = 2'b00;
    case (state_q)
      IDLE: begin
        gnt_c  = pick_gnt;
        bcnt_d = '0;
        if (gnt_c[P_CPU]) begin
          prio_d = 1'b1;
          if (lock0 && LOCK_OK) begin
            state_d = OWN0;
            bcnt_d  = BCNT_W'(1);
          end
        end else if (gnt_c[P_DMA]) begin
          prio_d = 1'b0;
          if (lock1 && LOCK_OK) begin
            state_d = OWN1;
            bcnt_d  = BCNT_W'(1);
          end
        end
      end
      OWN0: begin
        if (req0) begin
          gnt_c  = 2'b01;
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (!lock0 || (bcnt_d == BURST_LIM)) begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        if (req1) begin
          gnt_c  = 2'b10;
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (!lock1 || (bcnt_d == BURST_LIM)) begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (reset) begin
      gnt_c = 2'b00;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign gnt0    = gnt_c[P_CPU];
  assign gnt1    = gnt_c[P_DMA];
  assign load0_c = gnt_c[P_CPU] & ~we0;
  assign load1_c = gnt_c[P_DMA] & ~we1;

  // Memory mux: granted port drives the memory, port 0 when idle.
  always_comb begin
    mem_a  = addr0;
    mem_wd = wdata0;
    mem_we = gnt_c[P_CPU] & we0;
    if (gnt_c[P_DMA]) begin
      mem_a  = addr1;
      mem_wd = wdata1;
      mem_we = we1;
    end
  end

  // Load data capture: one-cycle rvalid, rdata held until next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= load0_c;
      rvalid1 <= load1_c;
      if (load0_c) begin
        rdata0 <= mem_rd;
      end
      if (load1_c) begin
        rdata1 <= mem_rd;
      end
    end
  end

`ifdef ARB_STATS_EN
  // Saturating per-port grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else begin
      if (gnt_c[P_CPU] && (gcnt0 != '1)) begin
        gcnt0 <= gcnt0 + GCNT_W'(1);
      end
      if (gnt_c[P_DMA] && (gcnt1 != '1)) begin
        gcnt1 <= gcnt1 + GCNT_W'(1);
      end
    end
  end

  // Both ports asking while exactly one of them is served.
  assign contention = req0 & req1 & (gnt_c[P_CPU] ^ gnt_c[P_DMA]);
`endif

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_dmem_arbiter;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 16;
  localparam int          MAXB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd, mem_rd;
`ifdef ARB_STATS_EN
  logic [15:0]   gcnt0, gcnt1;
  logic          contention;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef ARB_STATS_EN
    , .gcnt0(gcnt0), .gcnt1(gcnt1), .contention(contention)
`endif
  );

  // Data memory attached to the arbiter: async read, write on clock edge.
  logic [15:0] dmem [256];
  logic        init_mem;
  assign mem_rd = dmem[mem_a[8:1]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 16'(i * 16'h3b1) ^ 16'h5a5a;
    end else if (mem_we) begin
      dmem[mem_a[8:1]] <= mem_wd;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: owner (-1 = nobody), grants in current locked run,
  // favoured port for the next tie, reference memory, expected load results.
  int          own  = -1;
  int          run  = 0;
  int          fav  = 0;
  logic [15:0] ref_mem [256];
  logic        known = 1'b0;
  logic        erv0, erv1;
  logic [15:0] erd0, erd1;
  int          egc0, egc1;
  int          last_g;
  logic        obs_g0, obs_g1, obs_we;
  logic [15:0] obs_a;

  task automatic cycle(input logic rst,
                       input logic r0, input logic w0, input logic l0,
                       input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [15:0] a1, input logic [15:0] d1);
    int          g;
    logic [15:0] ea, ed;
    logic        ewe, lk;
    @(negedge clk);
    reset = rst;
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
    obs_g0 = gnt0; obs_g1 = gnt1; obs_we = mem_we; obs_a = mem_a;
    if (known) begin
      check_eq("rvalid0", 32'(rvalid0), 32'(erv0));
      check_eq("rvalid1", 32'(rvalid1), 32'(erv1));
      check_eq("rdata0", 32'(rdata0), 32'(erd0));
      check_eq("rdata1", 32'(rdata1), 32'(erd1));
`ifdef ARB_STATS_EN
      check_eq("gcnt0", 32'(gcnt0), 32'(egc0));
      check_eq("gcnt1", 32'(gcnt1), 32'(egc1));
`endif
    end
    if (rst)                g = -1;
    else if (own == 0)      g = r0 ? 0 : -1;
    else if (own == 1)      g = r1 ? 1 : -1;
    else if (r0 && r1)      g = fav;
    else if (r0)            g = 0;
    else if (r1)            g = 1;
    else                    g = -1;
    ea  = (g == 1) ? a1 : a0;
    ed  = (g == 1) ? d1 : d0;
    ewe = ((g == 0) && w0) || ((g == 1) && w1);
    check_eq("gnt0", 32'(gnt0), 32'(g == 0));
    check_eq("gnt1", 32'(gnt1), 32'(g == 1));
    check_eq("mem_we", 32'(mem_we), 32'(ewe));
    check_eq("mem_a", 32'(mem_a), 32'(ea));
    check_eq("mem_wd", 32'(mem_wd), 32'(ed));
`ifdef ARB_STATS_EN
    check_eq("contention", 32'(contention), 32'(r0 && r1 && (g >= 0)));
`endif
    last_g = g;
    if (rst) begin
      own = -1; run = 0; fav = 0;
      erv0 = 1'b0; erv1 = 1'b0; erd0 = '0; erd1 = '0;
      egc0 = 0; egc1 = 0;
      known = 1'b1;
    end else begin
      erv0 = (g == 0) && !w0;
      erv1 = (g == 1) && !w1;
      if (erv0) erd0 = ref_mem[a0[8:1]];
      if (erv1) erd1 = ref_mem[a1[8:1]];
      if (ewe) ref_mem[ea[8:1]] = ed;
      if (g == 0 && egc0 < 65535) egc0++;
      if (g == 1 && egc1 < 65535) egc1++;
      lk = (g == 0) ? l0 : l1;
      if (own < 0) begin
        if (g >= 0) begin
          fav = 1 - g;
          if (lk && MAXB > 1) begin
            own = g;
            run = 1;
          end
        end
      end else if (g < 0) begin
        own = -1;
      end else begin
        run++;
        if (!lk || run == MAXB) own = -1;
      end
    end
  endtask

  task automatic idle_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  logic [6:0]  pat;
  logic        pend0, pend1, pw0, pw1, rr0, rr1, rs;
  logic [15:0] pa0, pa1, pd0, pd1;

  initial begin
    reset = 1'b1; init_mem = 1'b1;
    req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 16'h3b1) ^ 16'h5a5a;
    idle_reset();
    idle_reset();
    init_mem = 1'b0;

    // Store then load on port 0 alone.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 16'h1234, 1'b0, 1'b0, 1'b0, '0, '0);
    check_eq("s1_gnt0", 32'(obs_g0), 32'd1);
    check_eq("s1_we", 32'(obs_we), 32'd1);
    check_eq("s1_addr", 32'(obs_a), 32'h0004);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    check_eq("s1_load_gnt", 32'(obs_g0), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    check_eq("s1_rvalid0", 32'(rvalid0), 32'd1);
    check_eq("s1_rdata0", 32'(rdata0), 32'h1234);

    // Contended loads without lock alternate 0,1,0,1...
    idle_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, '0, 1'b1, 1'b0, 1'b0, 16'h0020, '0);
      check_eq("s2_alt", 32'(obs_g1), 32'(i % 2));
    end
`ifdef ARB_STATS_EN
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    check_eq("s6_gcnt0", 32'(gcnt0), 32'd5);
    check_eq("s6_gcnt1", 32'(gcnt1), 32'd5);
`endif

    // Port 1 locked burst against a waiting port 0.
    idle_reset();
    pat = 7'b1011110;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, '0, 1'b1, 1'b0, 1'b1, 16'h0006, '0);
      check_eq("s3_gnt1", 32'(obs_g1), 32'(pat[i]));
      check_eq("s3_gnt0", 32'(obs_g0), 32'(!pat[i]));
    end

    // Reset during a locked port 1 burst with a load outstanding.
    idle_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 16'h0008, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 16'h0008, '0);
    check_eq("s4_gnt_in_reset", 32'({obs_g1, obs_g0}), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h000a, '0, 1'b1, 1'b0, 1'b0, 16'h0008, '0);
    check_eq("s4_rvalid1", 32'(rvalid1), 32'd0);
    check_eq("s4_rdata1", 32'(rdata1), 32'd0);
    check_eq("s4_tie_gnt0", 32'(obs_g0), 32'd1);

    // Owner drops its request: one dead cycle, then port 0 is served.
    idle_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 16'h0004, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h000c, 16'hbeef, 1'b0, 1'b0, 1'b1, '0, '0);
    check_eq("s5_nogrant", 32'({obs_g1, obs_g0}), 32'd0);
    check_eq("s5_nowe", 32'(obs_we), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h000c, 16'hbeef, 1'b0, 1'b0, 1'b0, '0, '0);
    check_eq("s5_gnt0", 32'(obs_g0), 32'd1);

    // Randomized traffic: requests held until granted, with occasional
    // drops, lock toggling and synchronous resets.
    pend0 = 0; pend1 = 0;
    pw0 = 0; pw1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!pend0 && $urandom_range(0, 99) < 60) begin
        pend0 = 1; pw0 = 1'($urandom_range(0, 1));
        pa0 = 16'($urandom_range(0, 31)); pd0 = 16'($urandom);
      end
      if (!pend1 && $urandom_range(0, 99) < 60) begin
        pend1 = 1; pw1 = 1'($urandom_range(0, 1));
        pa1 = 16'($urandom_range(0, 31)); pd1 = 16'($urandom);
      end
      rr0 = pend0 && ($urandom_range(0, 19) != 0);
      rr1 = pend1 && ($urandom_range(0, 19) != 0);
      rs  = ($urandom_range(0, 199) == 0);
      cycle(rs, rr0, pw0, 1'($urandom_range(0, 2) != 0), pa0, pd0,
                rr1, pw1, 1'($urandom_range(0, 2) != 0), pa1, pd1);
      if (last_g == 0) pend0 = 0;
      if (last_g == 1) pend1 = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dmem_arbiter
